// File: rtl/prz_pkg.sv
// Shared definitions for the prz core fetch stage: FSM encoding, next-PC
// source selection, JMPR offset field position and reset vector.
package prz_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_ABS  = 2'd2,
        SEL_REL  = 2'd3
    } pc_sel_t;

    localparam int unsigned JMPR_OFS_LSB = 4;
    localparam int unsigned RESET_VEC    = 0;

endpackage

// File: rtl/pc_tgt_calc.sv
// Combinational next-fetch-PC generator: sequential increment, absolute
// target, or JMPR-relative target (offset relative to the JMPR word itself).
module pc_tgt_calc
    import prz_pkg::*;
#(
    parameter int PC_WIDTH       = 16,
    parameter int JMPR_OFS_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0]       pc_f,
    input  logic [PC_WIDTH-1:0]       pc_d,
    input  logic [PC_WIDTH-1:0]       jmp_tgt,
    input  logic [JMPR_OFS_WIDTH-1:0] ofs,
    input  logic [1:0]                sel,
    output logic [PC_WIDTH-1:0]       next_pc
);

    logic [PC_WIDTH-1:0] ofs_sext;
    logic [PC_WIDTH-1:0] rel_tgt;
    logic [PC_WIDTH-1:0] seq_pc;

    // Both additions wrap modulo 2^PC_WIDTH by truncation.
    assign ofs_sext = {{(PC_WIDTH-JMPR_OFS_WIDTH){ofs[JMPR_OFS_WIDTH-1]}}, ofs};
    assign rel_tgt  = pc_d + ofs_sext;
    assign seq_pc   = pc_f + PC_WIDTH'(1);

    // Next-PC source mux
    always_comb begin
        next_pc = pc_f;
        case (pc_sel_t'(sel))
            SEL_HOLD: next_pc = pc_f;
            SEL_SEQ:  next_pc = seq_pc;
            SEL_ABS:  next_pc = jmp_tgt;
            SEL_REL:  next_pc = rel_tgt;
            default:  next_pc = pc_f;
        endcase
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and fetch sequencer of the prz core: drives the PRAM read
// address, tracks the address of the word on the PRAM output, resolves jumps/halt.
module pc_ctrl
    import prz_pkg::*;
#(
    parameter int INSTR_WIDTH    = 16,
    parameter int PC_WIDTH       = 16,
    parameter int JMPR_OFS_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [INSTR_WIDTH-1:0] out_data_pram_i,
    input  logic                   mask_i,
    input  logic                   jmpr_i,
    input  logic                   jmp_i,
    input  logic [PC_WIDTH-1:0]    jmp_tgt_i,
    input  logic                   halt_i,
    input  logic                   stall_i,
    output logic [PC_WIDTH-1:0]    pram_addr_o,
    output logic [PC_WIDTH-1:0]    pc_d_o,
    output logic                   instr_valid_o,
    output logic                   jmp_taken_o,
    output logic                   halted_o
);

    state_t              state_r;
    state_t              state_n;
    pc_sel_t             pc_sel;
    logic [PC_WIDTH-1:0] pc_f_r;
    logic [PC_WIDTH-1:0] pc_d_r;
    logic [PC_WIDTH-1:0] pc_d_n;
    logic [PC_WIDTH-1:0] pc_next;
    logic                unused_bits;

    assign unused_bits = ^{out_data_pram_i[INSTR_WIDTH-1:JMPR_OFS_LSB+JMPR_OFS_WIDTH],
                           out_data_pram_i[JMPR_OFS_LSB-1:0]};

    pc_tgt_calc #(
        .PC_WIDTH       (PC_WIDTH),
        .JMPR_OFS_WIDTH (JMPR_OFS_WIDTH)
    ) u_tgt (
        .pc_f    (pc_f_r),
        .pc_d    (pc_d_r),
        .jmp_tgt (jmp_tgt_i),
        .ofs     (out_data_pram_i[JMPR_OFS_LSB +: JMPR_OFS_WIDTH]),
        .sel     (pc_sel),
        .next_pc (pc_next)
    );

    // Next-state, next-PC selection and the combinational jump pulse
    always_comb begin
        state_n     = state_r;
        pc_sel      = SEL_HOLD;
        pc_d_n      = pc_d_r;
        jmp_taken_o = 1'b0;
        if (stall_i && (state_r != ST_HALT)) begin
            pc_sel = SEL_HOLD;
        end else begin
            case (state_r)
                // The FLUSH word is wrong-path: decoder strobes are ignored.
                ST_WAIT, ST_FLUSH: begin
                    state_n = ST_RUN;
                    pc_sel  = SEL_SEQ;
                    pc_d_n  = pc_f_r;
                end
                ST_RUN: begin
                    if (halt_i) begin
                        state_n = ST_HALT;
                    end else if (jmp_i) begin
                        state_n     = ST_FLUSH;
                        pc_sel      = SEL_ABS;
                        pc_d_n      = pc_f_r;
                        jmp_taken_o = ~rst_i;
                    end else if (jmpr_i && mask_i) begin
                        state_n     = ST_FLUSH;
                        pc_sel      = SEL_REL;
                        pc_d_n      = pc_f_r;
                        jmp_taken_o = ~rst_i;
                    end else begin
                        pc_sel = SEL_SEQ;
                        pc_d_n = pc_f_r;
                    end
                end
                ST_HALT: state_n = ST_HALT;
                default: state_n = ST_WAIT;
            endcase
        end
    end

    // State and PC registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_WAIT;
            pc_f_r  <= PC_WIDTH'(RESET_VEC);
            pc_d_r  <= PC_WIDTH'(RESET_VEC);
        end else begin
            state_r <= state_n;
            pc_f_r  <= pc_next;
            pc_d_r  <= pc_d_n;
        end
    end

    assign pram_addr_o   = pc_f_r;
    assign pc_d_o        = pc_d_r;
    assign instr_valid_o = (state_r == ST_RUN);
    assign halted_o      = (state_r == ST_HALT);

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic
// against a fetch-address reference model.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst, mask, jmpr, jmp, halt, stall;
    logic [15:0] data, tgt;
    logic [15:0] pram_addr, pc_d;
    logic        valid, taken, halted;
    int          errors = 0;
    int          checks = 0;

    // Reference model: address issued to PRAM, address of word on the output,
    // whether fetching has started, whether the current word is wrong-path.
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_pcd  = 16'h0000;
    bit          m_started = 1'b0;
    bit          m_discard = 1'b0;
    bit          m_halted  = 1'b0;
    logic [15:0] e_addr, e_pcd;
    logic        e_valid, e_taken, e_halted;

    always #5 clk = ~clk;

    pc_ctrl #(.INSTR_WIDTH(16), .PC_WIDTH(16), .JMPR_OFS_WIDTH(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .out_data_pram_i (data),
        .mask_i          (mask),
        .jmpr_i          (jmpr),
        .jmp_i           (jmp),
        .jmp_tgt_i       (tgt),
        .halt_i          (halt),
        .stall_i         (stall),
        .pram_addr_o     (pram_addr),
        .pc_d_o          (pc_d),
        .instr_valid_o   (valid),
        .jmp_taken_o     (taken),
        .halted_o        (halted)
    );

    task automatic drive(input logic r, input logic st, input logic h, input logic j,
                         input logic jr, input logic mk, input logic [15:0] tg,
                         input logic [15:0] dt);
        rst = r; stall = st; halt = h; jmp = j; jmpr = jr; mask = mk; tgt = tg; data = dt;
        #1;
        e_addr   = m_addr;
        e_pcd    = m_pcd;
        e_halted = m_halted;
        e_valid  = m_started && !m_discard && !m_halted;
        e_taken  = e_valid && !r && !st && !h && (j || (jr && mk));
    endtask

    task automatic adv();
        int          o;
        logic [15:0] old_pcd;
        if (rst) begin
            m_addr = 16'h0000; m_pcd = 16'h0000;
            m_started = 1'b0; m_discard = 1'b0; m_halted = 1'b0;
        end else if (m_halted || stall) begin
            m_addr = m_addr;
        end else if (!m_started || m_discard) begin
            m_pcd = m_addr; m_addr = m_addr + 16'd1;
            m_started = 1'b1; m_discard = 1'b0;
        end else if (halt) begin
            m_halted = 1'b1;
        end else if (jmp) begin
            m_pcd = m_addr; m_addr = tgt; m_discard = 1'b1;
        end else if (jmpr && mask) begin
            o = $signed(data[11:4]);
            old_pcd = m_pcd;
            m_pcd = m_addr;
            m_addr = 16'(int'(old_pcd) + o);
            m_discard = 1'b1;
        end else begin
            m_pcd = m_addr; m_addr = m_addr + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input logic [15:0] target);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        adv();
        for (int i = 0; i < 100 && !(m_pcd == target && m_started && !m_discard); i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'($urandom));
            adv();
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        adv(); adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pram_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", pram_addr); end
        checks++; if (pc_d !== 16'h0000) begin errors++; $display("FAIL reset_pcd got=%h exp=0000", pc_d); end
        checks++; if (valid !== 1'b0 || taken !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_flags got=%b%b%b exp=000", valid, taken, halted);
        end
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pram_addr !== 16'h0001 || pc_d !== 16'h0000 || valid !== 1'b1) begin
            errors++; $display("FAIL first_run got=%h/%h/%b exp=0001/0000/1", pram_addr, pc_d, valid);
        end
        for (int i = 0; i < 6; i++) begin
            adv();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'($urandom));
            checks++; if (pram_addr !== 16'(i + 2) || pc_d !== 16'(i + 1)) begin
                errors++; $display("FAIL seq_inc i=%0d got=%h/%h exp=%h/%h", i, pram_addr, pc_d, 16'(i + 2), 16'(i + 1));
            end
        end
        adv();
    endtask

    task automatic test_jmpr_taken();
        run_to(16'h0010);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0FC0);
        checks++; if (taken !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL jmpr_pulse got=%b/%b exp=1/1", taken, valid); end
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0FC0);
        checks++; if (pram_addr !== 16'h000C || valid !== 1'b0 || taken !== 1'b0) begin
            errors++; $display("FAIL jmpr_flush got=%h/%b/%b exp=000c/0/0", pram_addr, valid, taken);
        end
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pc_d !== 16'h000C || valid !== 1'b1 || pram_addr !== 16'h000D) begin
            errors++; $display("FAIL jmpr_land got=%h/%b/%h exp=000c/1/000d", pc_d, valid, pram_addr);
        end
        adv();
    endtask

    task automatic test_jmpr_not_taken();
        run_to(16'h0010);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0FC0);
        checks++; if (taken !== 1'b0) begin errors++; $display("FAIL jmpr_nt_pulse got=%b exp=0", taken); end
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pc_d !== 16'h0011 || valid !== 1'b1) begin
            errors++; $display("FAIL jmpr_nt_next got=%h/%b exp=0011/1", pc_d, valid);
        end
        adv();
    endtask

    task automatic test_jmp_wrap();
        run_to(16'h0003);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        checks++; if (taken !== 1'b1) begin errors++; $display("FAIL jmp_pulse got=%b exp=1", taken); end
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pc_d !== 16'hFFFF || valid !== 1'b1) begin errors++; $display("FAIL jmp_land got=%h/%b exp=ffff/1", pc_d, valid); end
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pc_d !== 16'h0000 || pram_addr !== 16'h0001) begin
            errors++; $display("FAIL wrap got=%h/%h exp=0000/0001", pc_d, pram_addr);
        end
        adv();
    endtask

    task automatic test_stall();
        run_to(16'h0010);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0FC0);
            checks++; if (taken !== 1'b0 || pram_addr !== 16'h0011 || pc_d !== 16'h0010 || valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold i=%0d got=%b/%h/%h/%b exp=0/0011/0010/1", i, taken, pram_addr, pc_d, valid);
            end
            adv();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0FC0);
        checks++; if (taken !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", taken); end
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pram_addr !== 16'h000C) begin errors++; $display("FAIL stall_target got=%h exp=000c", pram_addr); end
        adv();
    endtask

    task automatic test_halt();
        run_to(16'h0005);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        checks++; if (taken !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL halt_decide got=%b/%b exp=0/1", taken, valid); end
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b1, 16'($urandom), 16'($urandom));
            checks++; if (halted !== 1'b1 || pram_addr !== 16'h0006 || pc_d !== 16'h0005 || valid !== 1'b0 || taken !== 1'b0) begin
                errors++; $display("FAIL halt_frozen i=%0d got=%b/%h/%h/%b/%b exp=1/0006/0005/0/0", i, halted, pram_addr, pc_d, valid, taken);
            end
            adv();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (halted !== 1'b0 || pram_addr !== 16'h0000 || valid !== 1'b0) begin
            errors++; $display("FAIL halt_reset got=%b/%h/%b exp=0/0000/0", halted, pram_addr, valid);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  jsel [6] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};
        logic [15:0] dats [6] = '{16'h0000, 16'h0000, 16'h07F0, 16'h0000, 16'h0800, 16'h0000};
        logic [15:0] tgts [6] = '{16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_to(16'h0003);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, jsel[i] == 2'd1, jsel[i] == 2'd2, 1'b1, tgts[i], dats[i]);
            checks++; if (pram_addr !== e_addr || pc_d !== e_pcd || valid !== e_valid || taken !== e_taken) begin
                errors++; $display("FAIL b2b i=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", i, pram_addr, pc_d, valid, taken, e_addr, e_pcd, e_valid, e_taken);
            end
            adv();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (pc_d !== 16'h00FF || valid !== 1'b1) begin errors++; $display("FAIL b2b_final got=%h/%b exp=00ff/1", pc_d, valid); end
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(40) == 0,
                  $urandom_range(9) == 0, $urandom_range(3) == 0, 1'($urandom),
                  16'($urandom), 16'($urandom));
            checks++; if (pram_addr !== e_addr) begin errors++; $display("FAIL rand_addr i=%0d got=%h exp=%h", i, pram_addr, e_addr); end
            checks++; if (pc_d !== e_pcd) begin errors++; $display("FAIL rand_pcd i=%0d got=%h exp=%h", i, pc_d, e_pcd); end
            checks++; if (valid !== e_valid) begin errors++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, valid, e_valid); end
            checks++; if (taken !== e_taken) begin errors++; $display("FAIL rand_taken i=%0d got=%b exp=%b", i, taken, e_taken); end
            checks++; if (halted !== e_halted) begin errors++; $display("FAIL rand_halted i=%0d got=%b exp=%b", i, halted, e_halted); end
            adv();
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; halt = 1'b0; jmp = 1'b0; jmpr = 1'b0; mask = 1'b0;
        tgt = 16'h0000; data = 16'h0000;
        @(negedge clk);
        test_reset();
        test_jmpr_taken();
        test_jmpr_not_taken();
        test_jmp_wrap();
        test_stall();
        test_halt();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Program-counter and fetch-sequencing stage of the prz core.
- Drives the PRAM read address and tracks the address of the instruction currently presented on the PRAM output.
- Consumes the mask bit from the condition-mask stage to resolve conditional relative jumps (JMPR); also performs absolute jumps and halt.
- Inserts one bubble after every taken jump so the wrong-path instruction is never executed.

Parameters:
- INSTR_WIDTH, 16, PRAM word width.
- PC_WIDTH, 16, PRAM address width; PC arithmetic is modulo 2^PC_WIDTH.
- JMPR_OFS_WIDTH, 8, signed relative-jump offset width, taken from out_data_pram_i[JMPR_OFS_WIDTH+3:4].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- out_data_pram_i  in  INSTR_WIDTH  instruction word read from PRAM (valid one cycle after address).
- mask_i  in  1  condition result for the current word, from the condition-mask stage.
- jmpr_i  in  1  decoder: current word is JMPR.
- jmp_i  in  1  decoder: current word is absolute JMP.
- jmp_tgt_i  in  PC_WIDTH  absolute target (register operand).
- halt_i  in  1  decoder: current word is HALT.
- stall_i  in  1  freeze request from execute.
- pram_addr_o  out  PC_WIDTH  PRAM read address (= fetch PC).
- pc_d_o  out  PC_WIDTH  address of the word on out_data_pram_i.
- instr_valid_o  out  1  word on out_data_pram_i is to be executed.
- jmp_taken_o  out  1  one-cycle pulse on a taken jump.
- halted_o  out  1  core is halted.

Behaviour:
- Reset: rst_i is sampled on clk_i and overrides all other inputs.
  - Reset values: pram_addr_o=0, pc_d_o=0, instr_valid_o=0, jmp_taken_o=0, halted_o=0, state=WAIT.
- PRAM read is synchronous with 1-cycle latency. pc_d_o always equals the address that produced the current out_data_pram_i.
- States: WAIT, RUN, FLUSH, HALT.
  - WAIT: first cycle after reset; word 0 is being read. Go to RUN; pc_f <= pc_f+1; pc_d <= pc_f. instr_valid_o=0.
  - RUN: instr_valid_o=1 (combinational, qualified by state).
  - FLUSH: instr_valid_o=0. Next cycle returns to RUN and advances sequentially (pc_d <= pc_f, pc_f <= pc_f+1).
  - HALT: instr_valid_o=0, halted_o=1. pc_f and pc_d are frozen. Exited only by rst_i.
- Jump/halt resolution in RUN with stall_i=0, evaluated with priority halt > jmp > jmpr:
  - halt_i: next state HALT; the PC does not advance.
  - jmp_i: pc_f <= jmp_tgt_i; jmp_taken_o=1; next state FLUSH.
  - jmpr_i & mask_i: pc_f <= pc_d + sext(offset); jmp_taken_o=1; next state FLUSH.
  - jmpr_i & ~mask_i: not taken; sequential advance, no bubble.
  - otherwise: pc_d <= pc_f; pc_f <= pc_f+1.
- Offset is relative to the JMPR word itself: offset 0 means jump to self. Sign-extend to PC_WIDTH, then add modulo 2^PC_WIDTH; wrap in both directions is legal, no error.
- Sequential increment wraps 2^PC_WIDTH-1 -> 0.
- stall_i=1 in any state other than HALT:
  - Holds state, pc_f and pc_d.
  - Forces jmp_taken_o=0.
  - instr_valid_o keeps its state-derived value.
  - Decoder strobes are ignored until stall_i falls.
  - Stall in WAIT or FLUSH extends that state.
- The FLUSH-cycle word (wrong path) is discarded regardless of jmpr_i/jmp_i/halt_i.
- jmp_taken_o is combinational in the deciding cycle. pram_addr_o is registered (= pc_f).
- Reset mid-jump or mid-halt: the next cycle is WAIT with the PC at 0; no pending target survives.

Decomposition:
- Shared package prz_pkg holds:
  - state encoding localparams WAIT/RUN/FLUSH/HALT (2 bits);
  - JMPR offset field LSB position (4);
  - reset vector (0).
- One sub-module: pc_tgt_calc. It is combinational: sign-extends the offset, computes pc_d+offset and pc_f+1, and muxes the next-PC source.

Test Plan:
- Reset release → cycle 1: pram_addr_o=0, valid=0; cycle 2: pram_addr_o=1, pc_d_o=0, valid=1; then increments by 1 per cycle.
- JMPR at pc_d=0x0010, offset=0xFC, mask_i=1 → jmp_taken_o=1; next pram_addr_o=0x000C, one cycle valid=0; then pc_d_o=0x000C, valid=1.
- Same JMPR with mask_i=0 → no pulse, no bubble, pc_d_o=0x0011 next cycle.
- JMP with jmp_tgt_i=0xFFFF, then sequential run → pc_d_o=0xFFFF then 0x0000 (wrap).
- stall_i high for 3 cycles with jmpr_i & mask_i asserted → PC frozen, jmp_taken_o=0 throughout; the jump is taken on the first unstalled cycle.
- HALT at pc_d=0x0005 → halted_o=1, pram_addr_o frozen at 0x0006, valid=0; rst_i=1 for one cycle → WAIT, pram_addr_o=0, halted_o=0.
